// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared opcodes, FSM states and default latencies for the mult/div unit
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational HI/LO result generator for mult/multu/div/divu
// Divide-by-zero and overflow cases are resolved here so the result is never X.
module md_calc
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  md_op_e           op,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] w_sprod;
    logic [2*WIDTH-1:0] w_uprod;
    logic               w_a_neg;
    logic               w_b_neg;
    logic               w_b_zero;
    logic [WIDTH-1:0]   w_num;
    logic [WIDTH-1:0]   w_den;
    logic [WIDTH-1:0]   w_den_safe;
    logic [WIDTH-1:0]   w_q_mag;
    logic [WIDTH-1:0]   w_r_mag;

    assign w_sprod  = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_uprod  = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign w_a_neg  = a[WIDTH-1];
    assign w_b_neg  = b[WIDTH-1];
    assign w_b_zero = (b == '0);

    // One unsigned divider serves both flavours; signed divide works on magnitudes.
    // The most-negative / -1 case falls out naturally: its magnitude fits unsigned.
    assign w_num      = (op == MD_DIV && w_a_neg) ? -a : a;
    assign w_den      = (op == MD_DIV && w_b_neg) ? -b : b;
    assign w_den_safe = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_den;
    assign w_q_mag    = w_num / w_den_safe;
    assign w_r_mag    = w_num % w_den_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = w_sprod;
            MD_MULTU: {res_hi, res_lo} = w_uprod;
            MD_DIV: begin
                if (w_b_zero) begin
                    res_hi = a;
                    res_lo = {WIDTH{1'b1}};
                end else begin
                    res_lo = (w_a_neg ^ w_b_neg) ? -w_q_mag : w_q_mag;
                    res_hi = w_a_neg ? -w_r_mag : w_r_mag;
                end
            end
            MD_DIVU: begin
                if (w_b_zero) begin
                    res_hi = a;
                    res_lo = {WIDTH{1'b1}};
                end else begin
                    res_lo = w_q_mag;
                    res_hi = w_r_mag;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit with HI/LO registers and busy flag
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    md_state_e        r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    md_op_e           w_op;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_op = md_op_e'(op);

    md_calc #(.WIDTH(WIDTH)) u_calc (
        .a      (a),
        .b      (b),
        .op     (w_op),
        .res_hi (w_res_hi),
        .res_lo (w_res_lo)
    );

    // The result is captured at launch; the counter only models the latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (w_op)
                            MD_MULT, MD_MULTU: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_cnt     <= CW'(MULT_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_pend_hi <= w_res_hi;
                                r_pend_lo <= w_res_lo;
                                r_cnt     <= CW'(DIV_CYCLES);
                                r_busy    <= 1'b1;
                                r_state   <= S_RUN;
                            end
                            MD_MTHI: r_hi <= a;
                            MD_MTLO: r_lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_cnt == CW'(1)) begin
                        r_hi    <= r_pend_hi;
                        r_lo    <= r_pend_lo;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit against an arithmetic reference model
module tb_md_unit;

    localparam int NM = 5;
    localparam int ND = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_pass = 0;
    int          n_total = 0;
    int          edge_cnt = 0;
    int          model_free = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    exp_t        q[$];

    logic        mon_busy = 1'b0;
    logic        rst_seen = 1'b0;
    logic        mt_seen = 1'b0;
    int          busy_cnt = 0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32), .MULT_CYCLES(NM), .DIV_CYCLES(ND)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Reference: MIPS HI/LO semantics computed with 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] ch,
                                          input logic [31:0] cl);
        longint sx, sy, p, qq, rr;
        logic [63:0] u;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd0: begin p = sx * sy; return p; end
            3'd1: begin u = {32'd0, x} * {32'd0, y}; return u; end
            3'd2: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                qq = sx / sy;
                rr = sx % sy;
                return {rr[31:0], qq[31:0]};
            end
            3'd3: begin
                if (y == 32'd0) return {x, 32'hFFFFFFFF};
                return {x % y, x / y};
            end
            3'd4: return {x, cl};
            3'd5: return {ch, x};
            default: return {ch, cl};
        endcase
    endfunction

    task automatic churn();
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int e;
        logic [63:0] r;
        exp_t it;
        e = edge_cnt + 1;
        op = o; a = x; b = y; start = 1'b1;
        if (e >= model_free && o <= 3'd5) begin
            r = model(o, x, y, m_hi, m_lo);
            it.hi = r[63:32];
            it.lo = r[31:0];
            if (o <= 3'd1) begin it.cyc = NM; model_free = e + NM + 1; end
            else if (o <= 3'd3) begin it.cyc = ND; model_free = e + ND + 1; end
            else begin it.cyc = 0; model_free = e + 1; end
            m_hi = it.hi;
            m_lo = it.lo;
            q.push_back(it);
        end
        @(negedge clk);
        start = 1'b0;
        churn();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            churn();
        end
    endtask

    task automatic wait_free();
        while (edge_cnt + 1 < model_free) begin
            @(negedge clk);
            churn();
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        start = 1'b0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        model_free = 0;
        @(negedge clk);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            rst_seen = reset;
            mt_seen  = start && !reset && !mon_busy && (op == 3'd4 || op == 3'd5);
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_seen) begin
                q.delete();
                busy_cnt = 0;
                chk("reset_busy", {31'd0, busy}, 32'd0);
                chk("reset_hi", hi, 32'd0);
                chk("reset_lo", lo, 32'd0);
            end else begin
                if (busy) begin
                    busy_cnt++;
                    if (busy_cnt == 40) begin
                        n_total++;
                        $display("FAIL busy_timeout: busy held %0d cycles, expected at most %0d", busy_cnt, ND);
                    end
                end
                if ((mon_busy && !busy) || mt_seen) begin
                    if (q.size() == 0) begin
                        n_total++;
                        $display("FAIL unexpected_result: hi=%h lo=%h with no pending expectation", hi, lo);
                    end else begin
                        e = q.pop_front();
                        chk("result_hi", hi, e.hi);
                        chk("result_lo", lo, e.lo);
                        chk("busy_cycles", busy_cnt, e.cyc);
                    end
                    busy_cnt = 0;
                end
            end
            mon_busy = busy;
        end
    end

    initial begin
        int sel;
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        do_reset(2);

        drive(3'd0, 32'hFFFFFFFD, 32'd1);  wait_free();
        drive(3'd1, 32'hFFFFFFFD, 32'd1);  wait_free();
        drive(3'd2, 32'd7, 32'hFFFFFFFE);  wait_free();
        drive(3'd3, 32'd7, 32'd2);         wait_free();
        drive(3'd3, 32'h12345678, 32'd0);  wait_free();
        drive(3'd2, 32'h80000000, 32'hFFFFFFFF); wait_free();

        // A move issued while busy must be dropped and operands may churn mid-run.
        drive(3'd0, 32'd3, 32'd4);
        idle(1);
        drive(3'd4, 32'hDEAD, 32'd0);
        wait_free();
        idle(1);

        drive(3'd5, 32'h55, 32'd0);
        idle(1);
        drive(3'd2, 32'd1000, 32'd7);
        idle(3);
        do_reset(1);
        idle(15);
        chk("no_late_commit_hi", hi, 32'd0);
        chk("no_late_commit_lo", lo, 32'd0);
        chk("no_late_commit_busy", {31'd0, busy}, 32'd0);

        // Start on the completion edge is ignored; the next cycle is accepted.
        drive(3'd2, 32'd100, 32'd7);
        while (edge_cnt + 2 < model_free) begin
            @(negedge clk);
            churn();
        end
        drive(3'd0, 32'd9, 32'd9);
        drive(3'd0, 32'd2, 32'd3);
        wait_free();

        for (int i = 0; i < 40; i++) begin
            ro  = 3'($urandom_range(0, 7));
            rx  = $urandom;
            ry  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) ry = 32'd0;
            else if (sel == 1) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
            else if (sel == 2) begin rx = $urandom_range(0, 50); ry = $urandom_range(1, 9); end
            else if (sel == 3) ry = 32'($signed(-$urandom_range(1, 9)));
            drive(ro, rx, ry);
            if ($urandom_range(0, 3) != 0) wait_free();
            idle($urandom_range(0, 2));
        end

        wait_free();
        idle(3);
        chk("queue_empty", q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parameterised multi-cycle multiply/divide unit holding the HI/LO register pair.
- Successor to the single-cycle combinational ALU; sits beside the ALU in the EX stage of the pipelined CPU.
- Runs signed and unsigned mult/div over a fixed number of cycles and reports busy so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo.
- Also serves mthi/mtlo writes; HI/LO are read directly for mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- MULT_CYCLES, 5, busy duration of mult/multu; must be ≥ 1.
- DIV_CYCLES, 10, busy duration of div/divu; must be ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch the operation in op; sampled on a clk edge.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6 and 7 are NOP.
- a  input  WIDTH  operand A (rs): dividend, multiplicand, or the mthi/mtlo source.
- b  input  WIDTH  operand B (rt): divisor or multiplier.
- busy  output  1  an operation is in flight.
- hi  output  WIDTH  HI register (product high half / remainder).
- lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset: on a clk edge with reset=1, busy=0, hi=0, lo=0, counter=0, pending result cleared. This aborts any in-flight operation with no HI/LO commit, and takes priority over start.
- States: IDLE, RUN.
- IDLE accepts start:
  - MULT/MULTU/DIV/DIVU latch the full result into internal pend_hi/pend_lo at the start edge. Later changes on a/b have no effect.
  - The counter loads MULT_CYCLES or DIV_CYCLES. Go to RUN; busy=1 from the next cycle.
- RUN:
  - The counter decrements each edge.
  - On the edge where the counter reaches 0: hi<=pend_hi, lo<=pend_lo, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles. The new HI/LO are visible in the same cycle busy first reads 0.
- start while busy=1: ignored entirely, including MTHI/MTLO. The hazard unit stalls such instructions, so this is a protocol error that must be harmless.
- MTHI/MTLO in IDLE: single-cycle. hi<=a (or lo<=a) on that edge; busy stays 0; the other register is unchanged.
- NOP opcodes (6, 7) with start=1: no effect.
- Multiply:
  - MULT: full 2*WIDTH signed product of a and b; hi = upper half, lo = lower half.
  - MULTU: same, unsigned.
- Divide:
  - lo = quotient truncated toward zero; hi = remainder with the sign of the dividend (MIPS semantics).
  - DIV and DIVU with b=0: lo = all ones, hi = a. This is deterministic and never X.
  - DIV with a=most-negative and b=-1: lo = a, hi = 0.
- Simultaneous completion and start: on the completion edge the unit is still RUN, so that start is ignored. A new op can be accepted from the first busy=0 cycle.
- busy, hi and lo are driven straight from registers; no combinational path from inputs to outputs.

Decomposition:
- Shared package md_pkg:
  - op encodings MD_MULT..MD_MTLO;
  - state encoding S_IDLE/S_RUN;
  - default cycle constants.
- Sub-module md_calc: purely combinational (a, b, op) -> {res_hi, res_lo}. It owns the signed/unsigned handling and all divide edge cases, and can be unit-tested standalone.
- md_unit owns the FSM, the counter, the pend registers and HI/LO.

Test Plan:
1. MULT a=32'hFFFFFFFD (-3), b=1 -> busy high exactly 5 cycles, then hi=32'hFFFFFFFF, lo=32'hFFFFFFFD. MULTU with the same operands -> hi=0, lo=32'hFFFFFFFD.
2. DIV a=7, b=32'hFFFFFFFE (-2) -> after 10 busy cycles lo=32'hFFFFFFFD (-3), hi=1. DIVU a=7, b=2 -> lo=3, hi=1.
3. DIVU a=32'h12345678, b=0 -> lo=32'hFFFFFFFF, hi=32'h12345678. DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
4. Start MULT 3*4, then pulse start with MTHI a=32'hDEAD during busy, and change a/b mid-run -> MTHI ignored; final hi=0, lo=12.
5. MTLO a=32'h55 while idle -> lo=32'h55 next edge, busy stays 0, hi unchanged. Then start DIV and assert reset at busy cycle 4 -> busy=0, hi=0, lo=0 the next cycle, and no late commit afterwards.
6. Back-to-back: issue MULT 2*3 on the first cycle busy reads 0 after a previous DIV -> accepted; busy holds 5 more cycles; lo=6.
